// File: rtl/sim_run_ctrl_if.sv
//----------------------------------------------------------------------------
// sim_run_ctrl_if : run-control bundle between harness top and run sequencer
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface sim_run_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             start_i;
  logic             boot_sel_i;
  logic [CNT_W-1:0] max_cycles_i;
  logic             load_done_i;
  logic             exit_valid_i;
  logic [31:0]      exit_value_i;

  logic             dut_rst_no;
  logic             load_req_o;
  logic             set_exit_loop_o;
  logic             run_active_o;
  logic             done_o;
  logic [1:0]       status_o;
  logic [31:0]      exit_value_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  modport master (
    output start_i, boot_sel_i, max_cycles_i, load_done_i, exit_valid_i, exit_value_i,
    input  dut_rst_no, load_req_o, set_exit_loop_o, run_active_o, done_o,
           status_o, exit_value_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, boot_sel_i, max_cycles_i, load_done_i, exit_valid_i, exit_value_i,
    output dut_rst_no, load_req_o, set_exit_loop_o, run_active_o, done_o,
           status_o, exit_value_o, cycle_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
//----------------------------------------------------------------------------
// sim_run_ctrl : reset / firmware-load / exit / cycle-limit run sequencer
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module sim_run_ctrl #(
  parameter int RESET_WAIT_CYCLES = 50,
  parameter int CNT_W             = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  sim_run_ctrl_if.slave  bus
);

  localparam int WAIT_W = (RESET_WAIT_CYCLES > 0) ? $clog2(RESET_WAIT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] c_wait_last =
    WAIT_W'((RESET_WAIT_CYCLES > 0) ? RESET_WAIT_CYCLES - 1 : 0);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_hold     = 3'd1;
  localparam logic [2:0] c_post     = 3'd2;
  localparam logic [2:0] c_load     = 3'd3;
  localparam logic [2:0] c_exitloop = 3'd4;
  localparam logic [2:0] c_run      = 3'd5;
  localparam logic [2:0] c_done     = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_boot_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dut_rst_n;
  logic              r_load_req;
  logic              r_set_exit;
  logic              r_run_active;
  logic              r_done;
  logic [1:0]        r_status;
  logic [31:0]       r_exit_val;

  logic w_timeout;
  logic w_wait_done;
  logic w_counting;
  logic w_exit;

  assign w_timeout   = (bus.max_cycles_i != '0) && (r_cnt >= bus.max_cycles_i);
  assign w_wait_done = (r_wait == c_wait_last);
  assign w_counting  = (r_state == c_post) || (r_state == c_load) ||
                       (r_state == c_exitloop) || (r_state == c_run);
  assign w_exit      = (r_state == c_run) && bus.exit_valid_i;

  // Exit is tested before timeout in RUN so a coincident strobe wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:     if (bus.start_i) w_next = c_hold;
      c_hold:     if (w_wait_done) w_next = c_post;
      c_post:     if (w_timeout) w_next = c_done;
                  else if (w_wait_done) w_next = r_boot_sel ? c_run : c_load;
      c_load:     if (w_timeout) w_next = c_done;
                  else if (bus.load_done_i) w_next = c_exitloop;
      c_exitloop: w_next = w_timeout ? c_done : c_run;
      c_run:      if (w_exit || w_timeout) w_next = c_done;
      c_done:     if (bus.start_i) w_next = c_hold;
      default:    w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= c_idle;
      r_wait       <= '0;
      r_boot_sel   <= 1'b0;
      r_cnt        <= '0;
      r_dut_rst_n  <= 1'b0;
      r_load_req   <= 1'b0;
      r_set_exit   <= 1'b0;
      r_run_active <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= 2'b00;
      r_exit_val   <= '0;
    end else begin
      r_state      <= w_next;
      // Outputs are decoded from the next state so they change on the transition edge.
      r_dut_rst_n  <= (w_next != c_idle) && (w_next != c_hold);
      r_load_req   <= (w_next == c_load);
      r_set_exit   <= (w_next == c_exitloop);
      r_run_active <= (w_next == c_run);
      r_done       <= (w_next == c_done);

      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == c_hold) || (r_state == c_post)) begin
        r_wait <= r_wait + 1'b1;
      end

      if (w_next == c_hold && r_state != c_hold) begin
        r_boot_sel <= bus.boot_sel_i;
        r_cnt      <= '0;
        r_status   <= 2'b00;
        r_exit_val <= '0;
      end else begin
        if (w_counting && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_exit) begin
          r_exit_val <= bus.exit_value_i;
          r_status   <= (bus.exit_value_i == 32'd0) ? 2'b01 : 2'b10;
        end else if (w_next == c_done && r_state != c_done) begin
          r_status   <= 2'b11;
        end
      end
    end
  end

  assign bus.dut_rst_no      = r_dut_rst_n;
  assign bus.load_req_o      = r_load_req;
  assign bus.set_exit_loop_o = r_set_exit;
  assign bus.run_active_o    = r_run_active;
  assign bus.done_o          = r_done;
  assign bus.status_o        = r_status;
  assign bus.exit_value_o    = r_exit_val;
  assign bus.cycle_cnt_o     = r_cnt;

endmodule

`default_nettype wire
